osc_bank_reader: RTL and testbench

Measurement controller for the ring-oscillator counter bank.
- Owns the bank's reset line and address select.
- Runs a timed count window, then sweeps the bank pair by pair and compares adjacent counters.
- Packs one response bit per pair and hands the word upstream over a valid/ready handshake.
- Sits between the oscillator bank and the RSA/key-generation logic that consumes response words.

---
 rtl/osc_bank_reader.sv | 154 +++++++++++++++
 tb/tb_osc_bank_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/osc_bank_reader.sv
// Ring-oscillator bank measurement controller: timed count window, pairwise sweep,
// response word over valid/ready. Optional raw-capture trace: OSC_BANK_READER_RAW_EN.
module osc_bank_reader #(
  parameter int COUNTER_LENGTH = 128,
  parameter int BANK_SIZE      = 16,
  parameter int ADDRESS_SIZE   = 4,
  parameter int WINDOW_CYCLES  = 1024,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DROP_LSBS      = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      START,
  output logic                      BUSY,
  output logic                      OSC_RESET,
  output logic [ADDRESS_SIZE-1:0]   ADDRESS,
  input  logic [COUNTER_LENGTH-1:0] COUNT,
  output logic [BANK_SIZE/2-1:0]    RESPONSE,
  output logic                      RESP_VALID,
  output logic [2:0]                state_dbg,
`ifdef OSC_BANK_READER_RAW_EN
  output logic                      RAW_VALID,
  output logic [ADDRESS_SIZE-1:0]   RAW_ADDR,
  output logic [COUNTER_LENGTH-1:0] RAW_COUNT,
`endif
  input  logic                      RESP_READY
);

  localparam int HALF  = BANK_SIZE / 2;
  localparam int DW    = COUNTER_LENGTH - DROP_LSBS;
  localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [WIN_W-1:0]        LAST_WIN  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [SET_W-1:0]        LAST_SET  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(BANK_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_SAMPLE_A, S_SAMPLE_B, S_DONE} state_t;

  state_t            state_q;
  logic [WIN_W-1:0]  win_cnt;
  logic [SET_W-1:0]  set_cnt;
  logic [DW-1:0]     a_q;
  logic [HALF-1:0]   resp_sr;
  logic [HALF-1:0]   resp_next;
  logic [DW-1:0]     count_drop;
  logic              a_gt_b;
  logic              set_last;

  assign state_dbg  = state_q;
  assign count_drop = COUNT[COUNTER_LENGTH-1:DROP_LSBS];
  assign a_gt_b     = a_q > count_drop;
  assign set_last   = (set_cnt == LAST_SET);
  // Pair k lands in bit k after all HALF shifts, since bits enter at the top.
  assign resp_next  = (resp_sr >> 1) | (HALF'(a_gt_b) << (HALF - 1));

  // Handshake: RESPONSE is held stable while RESP_VALID is high; the word is
  // transferred on any cycle where RESP_VALID and RESP_READY are both high.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      OSC_RESET  <= 1'b1;
      ADDRESS    <= '0;
      BUSY       <= 1'b0;
      RESPONSE   <= '0;
      RESP_VALID <= 1'b0;
      win_cnt    <= '0;
      set_cnt    <= '0;
      a_q        <= '0;
      resp_sr    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (START) begin
            state_q   <= S_RUN;
            BUSY      <= 1'b1;
            OSC_RESET <= 1'b0;
            win_cnt   <= '0;
          end
        end
        S_RUN: begin
          if (win_cnt == LAST_WIN) begin
            state_q <= S_SAMPLE_A;
            ADDRESS <= '0;
            set_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        S_SAMPLE_A: begin
          if (set_last) begin
            a_q     <= count_drop;
            set_cnt <= '0;
            ADDRESS <= ADDRESS + 1'b1;
            state_q <= S_SAMPLE_B;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        S_SAMPLE_B: begin
          if (set_last) begin
            resp_sr <= resp_next;
            set_cnt <= '0;
            if (ADDRESS == LAST_ADDR) begin
              state_q    <= S_DONE;
              ADDRESS    <= '0;
              OSC_RESET  <= 1'b1;
              RESPONSE   <= resp_next;
              RESP_VALID <= 1'b1;
            end else begin
              ADDRESS <= ADDRESS + 1'b1;
              state_q <= S_SAMPLE_A;
            end
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (RESP_READY) begin
            state_q    <= S_IDLE;
            RESP_VALID <= 1'b0;
            BUSY       <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef OSC_BANK_READER_RAW_EN
  // Trace of every capture, one cycle after it, with the full undropped count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RAW_VALID <= 1'b0;
      RAW_ADDR  <= '0;
      RAW_COUNT <= '0;
    end else begin
      RAW_VALID <= 1'b0;
      if ((state_q == S_SAMPLE_A || state_q == S_SAMPLE_B) && set_last) begin
        RAW_VALID <= 1'b1;
        RAW_ADDR  <= ADDRESS;
        RAW_COUNT <= COUNT;
      end
    end
  end
`else
  generate
    if (DROP_LSBS > 0) begin : g_drop
      logic unused_count_lsbs;
      assign unused_count_lsbs = ^COUNT[DROP_LSBS-1:0];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_osc_bank_reader.sv
// Directed bench for osc_bank_reader: table of bank patterns with expected responses,
// plus reset-abort sequence. Raw trace checks enabled by OSC_BANK_READER_RAW_EN.
module tb_osc_bank_reader;

  logic         clk = 1'b0;
  logic         reset, start, resp_ready;
  logic         busy, osc_reset, resp_valid;
  logic [3:0]   address;
  logic [127:0] count;
  logic [7:0]   response;
  logic [2:0]   state_dbg;
`ifdef OSC_BANK_READER_RAW_EN
  logic         raw_valid;
  logic [3:0]   raw_addr;
  logic [127:0] raw_count;
`endif

  logic [127:0] bank_val [16];
  logic [7:0]   exp_q [$];
  int           checks = 0;
  int           errors = 0;
  int           raw_idx, raw_bad;

  assign count = bank_val[address];

  osc_bank_reader dut (
    .CLK(clk), .RESET(reset), .START(start), .BUSY(busy), .OSC_RESET(osc_reset),
    .ADDRESS(address), .COUNT(count), .RESPONSE(response), .RESP_VALID(resp_valid),
    .state_dbg(state_dbg),
`ifdef OSC_BANK_READER_RAW_EN
    .RAW_VALID(raw_valid), .RAW_ADDR(raw_addr), .RAW_COUNT(raw_count),
`endif
    .RESP_READY(resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] a_val [8];
    logic [127:0] b_val [8];
    logic [7:0]   exp;
    int           ready_delay;
    bit           spam;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raw_sample();
`ifdef OSC_BANK_READER_RAW_EN
    if (raw_valid === 1'b1) begin
      if (raw_idx > 15 || raw_addr !== 4'(raw_idx) || raw_count !== bank_val[raw_idx[3:0]])
        raw_bad++;
      raw_idx++;
    end
`endif
  endtask

  task automatic load_bank(input int vi);
    for (int k = 0; k < 8; k++) begin
      bank_val[2*k]   = vecs[vi].a_val[k];
      bank_val[2*k+1] = vecs[vi].b_val[k];
    end
  endtask

  task automatic measure(input int vi);
    int c, addr_bad, run_bad, hold_bad;
    logic [7:0] got, expv;
    load_bank(vi);
    exp_q.push_back(vecs[vi].exp);
    raw_idx = 0; raw_bad = 0;
    addr_bad = 0; run_bad = 0; hold_bad = 0;
    resp_ready = (vecs[vi].ready_delay == 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("osc_reset_low_at_start", osc_reset, 0);
    c = 0;
    while (resp_valid !== 1'b1 && c < 1200) begin
      if (c < 1024 && address !== 4'd0) addr_bad++;
      if (c >= 1024 && address !== 4'((c - 1024) / 4)) addr_bad++;
      if (osc_reset !== 1'b0 || busy !== 1'b1) run_bad++;
      raw_sample();
      start = vecs[vi].spam && (c == 5 || c == 1030 || c == 1061);
      step();
      c++;
    end
    start = 1'b0;
    check("valid_latency", c, 1088);
    check("address_sequence", addr_bad, 0);
    check("osc_reset_busy_during_run", run_bad, 0);
    raw_sample();
    check("done_osc_reset", osc_reset, 1);
    check("done_address", address, 0);
    check("done_busy", busy, 1);
    got = response;
    for (int i = 0; i < vecs[vi].ready_delay; i++) begin
      start = (i == 0);
      step();
      if (resp_valid !== 1'b1 || busy !== 1'b1 || response !== got) hold_bad++;
    end
    if (vecs[vi].ready_delay > 0) check("done_hold_stable", hold_bad, 0);
    expv = exp_q.pop_front();
    check("response", got, expv);
    start = 1'b1;
    resp_ready = 1'b1;
    step();
    start = 1'b0;
    resp_ready = 1'b0;
    check("valid_drop", resp_valid, 0);
    check("busy_drop", busy, 0);
    check("idle_osc_reset", osc_reset, 1);
    check("response_retained", response, expv);
    step();
    check("start_at_handshake_ignored", busy, 0);
`ifdef OSC_BANK_READER_RAW_EN
    check("raw_pulse_count", raw_idx, 16);
    check("raw_addr_count", raw_bad, 0);
`endif
  endtask

  initial begin
    // vec0: count = 1000 + 10*addr, every pair has A < B
    for (int k = 0; k < 8; k++) begin
      vecs[0].a_val[k] = 128'(1000 + 20*k);
      vecs[0].b_val[k] = 128'(1010 + 20*k);
      vecs[1].a_val[k] = 128'd500;
      vecs[1].b_val[k] = 128'd400;
      vecs[3].a_val[k] = (k % 2 == 0) ? 128'd500 : 128'd400;
      vecs[3].b_val[k] = (k % 2 == 0) ? 128'd400 : 128'd500;
    end
    vecs[0].exp = 8'h00; vecs[0].ready_delay = 0;  vecs[0].spam = 1'b0;
    vecs[1].exp = 8'hFF; vecs[1].ready_delay = 20; vecs[1].spam = 1'b1;
    vecs[3].exp = 8'h55; vecs[3].ready_delay = 0;  vecs[3].spam = 1'b1;
    // vec2: ties and dropped-LSB corners; bits 7..0 = 1,1,0,1,0,1,0,0
    vecs[2].a_val[0] = 128'd400;  vecs[2].b_val[0] = 128'd400;
    vecs[2].a_val[1] = 128'd401;  vecs[2].b_val[1] = 128'd400;
    vecs[2].a_val[2] = 128'd404;  vecs[2].b_val[2] = 128'd400;
    vecs[2].a_val[3] = 128'd400;  vecs[2].b_val[3] = 128'd404;
    vecs[2].a_val[4] = {1'b1, 127'd0}; vecs[2].b_val[4] = 128'd1;
    vecs[2].a_val[5] = 128'd0;    vecs[2].b_val[5] = 128'd0;
    vecs[2].a_val[6] = 128'd7;    vecs[2].b_val[6] = 128'd3;
    vecs[2].a_val[7] = 128'd1000; vecs[2].b_val[7] = 128'd999;
    vecs[2].exp = 8'hD4; vecs[2].ready_delay = 3; vecs[2].spam = 1'b0;

    for (int i = 0; i < 16; i++) bank_val[i] = '0;
    reset = 1'b1; start = 1'b0; resp_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_osc_reset", osc_reset, 1);
    check("rst_address", address, 0);
    check("rst_busy", busy, 0);
    check("rst_response", response, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_state", state_dbg, 0);
`ifdef OSC_BANK_READER_RAW_EN
    check("rst_raw_valid", raw_valid, 0);
    check("rst_raw_addr", raw_addr, 0);
    check("rst_raw_count", raw_count, 0);
`endif
    step();

    for (int vi = 0; vi < 4; vi++) measure(vi);

    // Abort in SAMPLE_B of pair 3 (address 7); prior response 8'h55 must be cleared.
    load_bank(1);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (1053) step();
    check("abort_point_address", address, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_state", state_dbg, 0);
    check("abort_osc_reset", osc_reset, 1);
    check("abort_address", address, 0);
    check("abort_valid", resp_valid, 0);
    check("abort_response", response, 0);
    check("abort_busy", busy, 0);
    step();
    measure(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
